// File: rtl/descrambler_lock_pkg.sv
// Shared definitions for the 64b/66b receive descrambler and block-lock logic.
//   - lock_state_t : block-lock FSM states
//   - HDR_DATA / HDR_CTRL : the two legal sync headers
//   - TAP_A / TAP_B : taps of the x^58 + x^39 + 1 self-synchronous polynomial
//   - hdr_is_valid() : legal-header test used by the lock FSM and hdr_err flag
package descrambler_lock_pkg;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } lock_state_t;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam int TAP_A  = 39;
  localparam int TAP_B  = 58;
  localparam int HIST_W = TAP_B;  // history depth equals the longest tap
  localparam int DATA_W = 64;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/descrambler_lock_if.sv
// Block stream bundle between the aligner, the descrambler/lock block and
// the downstream decoder.
//   slave  : the descrambler side (consumes rx_*, produces out_*/lock/slip)
//   master : the environment side (produces rx_*, consumes the results)
interface descrambler_lock_if;

  logic        rx_valid;
  logic [1:0]  rx_header;
  logic [63:0] rx_data;

  logic        out_valid;
  logic [1:0]  out_header;
  logic [63:0] out_data;
  logic        out_hdr_err;
  logic        block_lock;
  logic        slip;

  modport slave (
    input  rx_valid, rx_header, rx_data,
    output out_valid, out_header, out_data, out_hdr_err, block_lock, slip
  );

  modport master (
    output rx_valid, rx_header, rx_data,
    input  out_valid, out_header, out_data, out_hdr_err, block_lock, slip
  );

endinterface

// File: rtl/descrambler_core.sv
// Self-synchronous x^58 + x^39 + 1 descrambler for one 64-bit payload.
//   clk      : clock
//   srst     : synchronous active-high reset (clears the history)
//   en       : a block is present; advances the history
//   data_in  : scrambled payload, bit 0 first on the line
//   data_out : descrambled payload (combinational from data_in and history)
module descrambler_core
  import descrambler_lock_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  // Only the part of the line stream that a tap can reach is assembled:
  // the highest index used is (DATA_W-1) + (TAP_B-TAP_A).
  localparam int TAP_D = TAP_B - TAP_A;
  localparam int S_W   = DATA_W + TAP_D;

  logic [HIST_W-1:0] prev_reg;  // prev_reg[k] = scrambled bit k+6 of last block
  logic [S_W-1:0]    s_vec;

  assign s_vec = {data_in[S_W-HIST_W-1:0], prev_reg};

  // Bit i sees the line bit 39 positions earlier (s_vec[i+19]) and the one
  // 58 positions earlier (s_vec[i]); both may fall inside the current block.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_xor
      assign data_out[gi] = data_in[gi] ^ s_vec[gi+TAP_D] ^ s_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= '0;
    end else if (en) begin
      prev_reg <= data_in[DATA_W-1:DATA_W-HIST_W];
    end
  end

endmodule

// File: rtl/descrambler_lock.sv
// 64b/66b receive path: descrambles the payload and runs block lock on the
// sync headers, requesting a one-bit slip from the aligner on bad alignment.
//   CLK   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : block stream (rx_* in; out_*, block_lock, slip out), 1-cycle latency
module descrambler_lock
  import descrambler_lock_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 16,
  parameter int SLIP_HOLD = 2
) (
  input  logic               CLK,
  input  logic               reset,
  descrambler_lock_if.slave  bus
);

  localparam int MAX_A = (LOCK_CNT > WINDOW) ? LOCK_CNT : WINDOW;
  localparam int MAX_B = (ERR_LIMIT > SLIP_HOLD) ? ERR_LIMIT : SLIP_HOLD;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] LOCK_CNT_C  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] WINDOW_C    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ERR_LIMIT_C = CNT_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] SLIP_HOLD_C = CNT_W'(SLIP_HOLD);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  lock_state_t      state_reg, state_next;
  logic [CNT_W-1:0] good_cnt_reg, good_cnt_next;
  logic [CNT_W-1:0] win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic             block_lock_reg, block_lock_next;
  logic             slip_reg, slip_next;

  logic             out_valid_reg;
  logic [1:0]       out_header_reg;
  logic [63:0]      out_data_reg;
  logic             out_hdr_err_reg;

  logic             hdr_ok;
  logic [63:0]      desc_data;
  logic [CNT_W-1:0] good_inc, win_inc, err_inc, hold_inc;

  assign hdr_ok   = hdr_is_valid(bus.rx_header);
  assign good_inc = sat_inc(good_cnt_reg);
  assign win_inc  = sat_inc(win_cnt_reg);
  assign err_inc  = hdr_ok ? err_cnt_reg : sat_inc(err_cnt_reg);
  assign hold_inc = sat_inc(hold_cnt_reg);

  descrambler_core u_core (
    .clk      (CLK),
    .srst     (reset),
    .en       (bus.rx_valid),
    .data_in  (bus.rx_data),
    .data_out (desc_data)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg      <= ST_HUNT;
      good_cnt_reg   <= '0;
      win_cnt_reg    <= '0;
      err_cnt_reg    <= '0;
      hold_cnt_reg   <= '0;
      block_lock_reg <= 1'b0;
      slip_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      good_cnt_reg   <= good_cnt_next;
      win_cnt_reg    <= win_cnt_next;
      err_cnt_reg    <= err_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      block_lock_reg <= block_lock_next;
      slip_reg       <= slip_next;
    end
  end

  // The FSM only moves on cycles carrying a block; slip is a single-cycle
  // pulse because its default is 0 and it is set only on a block cycle.
  always_comb begin
    state_next      = state_reg;
    good_cnt_next   = good_cnt_reg;
    win_cnt_next    = win_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    block_lock_next = block_lock_reg;
    slip_next       = 1'b0;
    if (bus.rx_valid) begin
      case (state_reg)
        ST_HUNT: begin
          if (hdr_ok) begin
            good_cnt_next = good_inc;
            if (good_inc == LOCK_CNT_C) begin
              state_next      = ST_LOCKED;
              block_lock_next = 1'b1;
              good_cnt_next   = '0;
              win_cnt_next    = '0;
              err_cnt_next    = '0;
            end
          end else begin
            slip_next     = 1'b1;
            good_cnt_next = '0;
            hold_cnt_next = '0;
            state_next    = ST_SLIP_WAIT;
          end
        end
        ST_LOCKED: begin
          // Error limit beats window end when both land on the same block.
          if (err_inc == ERR_LIMIT_C) begin
            block_lock_next = 1'b0;
            slip_next       = 1'b1;
            hold_cnt_next   = '0;
            win_cnt_next    = '0;
            err_cnt_next    = '0;
            state_next      = ST_SLIP_WAIT;
          end else if (win_inc == WINDOW_C) begin
            win_cnt_next = '0;
            err_cnt_next = '0;
          end else begin
            win_cnt_next = win_inc;
            err_cnt_next = err_inc;
          end
        end
        ST_SLIP_WAIT: begin
          // Blocks right after a slip straddle the old and new alignment,
          // so their headers are not trusted.
          if (hold_inc == SLIP_HOLD_C) begin
            hold_cnt_next = '0;
            good_cnt_next = '0;
            state_next    = ST_HUNT;
          end else begin
            hold_cnt_next = hold_inc;
          end
        end
        default: begin
          state_next = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_header_reg  <= 2'b00;
      out_data_reg    <= '0;
      out_hdr_err_reg <= 1'b0;
    end else begin
      out_valid_reg   <= bus.rx_valid;
      out_header_reg  <= bus.rx_header;
      out_data_reg    <= desc_data;
      out_hdr_err_reg <= ~hdr_ok;
    end
  end

  assign bus.out_valid   = out_valid_reg;
  assign bus.out_header  = out_header_reg;
  assign bus.out_data    = out_data_reg;
  assign bus.out_hdr_err = out_hdr_err_reg;
  assign bus.block_lock  = block_lock_reg;
  assign bus.slip        = slip_reg;

endmodule

// File: tb/tb_descrambler_lock.sv
// Scoreboard bench for descrambler_lock: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_descrambler_lock;

  logic CLK;
  logic reset;

  descrambler_lock_if bus ();

  descrambler_lock #(
    .LOCK_CNT  (64),
    .WINDOW    (64),
    .ERR_LIMIT (16),
    .SLIP_HOLD (2)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    logic        chk_data;
    logic [1:0]  header;
    logic        hdr_err;
    logic        lock;
    logic        slip;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  logic [57:0] scr_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: one line per output transaction.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=out_valid required=empty_queue");
      end else begin
        e = exp_q.pop_front();
        $display("txn hdr=%b data=%h err=%b lock=%b slip=%b", bus.out_header,
                 bus.out_data, bus.out_hdr_err, bus.block_lock, bus.slip);
        if (e.chk_data) chk("out_data", bus.out_data, e.data);
        chk("out_header", 64'(bus.out_header), 64'(e.header));
        chk("out_hdr_err", 64'(bus.out_hdr_err), 64'(e.hdr_err));
        chk("block_lock", 64'(bus.block_lock), 64'(e.lock));
        chk("slip", 64'(bus.slip), 64'(e.slip));
      end
    end else begin
      chk("slip_idle", 64'(bus.slip), 64'd0);
    end
  end

  task automatic drive(input logic v, input logic [1:0] h, input logic [63:0] d, input exp_t e);
    bus.rx_valid  = v;
    bus.rx_header = h;
    bus.rx_data   = d;
    if (v) exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic blk(input logic [1:0] h, input logic [63:0] d, input logic cd,
                     input logic [63:0] ed, input logic lk, input logic sl);
    exp_t e;
    e.data     = ed;
    e.chk_data = cd;
    e.header   = h;
    e.hdr_err  = !((h == 2'b01) || (h == 2'b10));
    e.lock     = lk;
    e.slip     = sl;
    drive(1'b1, h, d, e);
  endtask

  task automatic idle();
    exp_t e;
    e = '{default: '0};
    drive(1'b0, 2'b00, 64'd0, e);
  endtask

  task automatic reset_dut();
    reset         = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_header = 2'b00;
    bus.rx_data   = 64'd0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  // Golden transmit scrambler, serial form: scr_state[0] is the newest line bit.
  task automatic scramble(input logic [63:0] d, output logic [63:0] q);
    logic b;
    q = '0;
    for (int j = 0; j < 64; j++) begin
      b         = d[j] ^ scr_state[38] ^ scr_state[57];
      q[j]      = b;
      scr_state = {scr_state[56:0], b};
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  64'(bus.out_valid),   64'd0);
    chk({tag, "_header"}, 64'(bus.out_header),  64'd0);
    chk({tag, "_data"},   bus.out_data,         64'd0);
    chk({tag, "_hdrerr"}, 64'(bus.out_hdr_err), 64'd0);
    chk({tag, "_lock"},   64'(bus.block_lock),  64'd0);
    chk({tag, "_slip"},   64'(bus.slip),        64'd0);
  endtask

  initial begin
    logic [63:0] pay;
    logic [63:0] scr;
    logic [1:0]  h;
    int          n_valid;

    checks   = 0;
    failures = 0;
    reset_dut();
    chk_all_zero("reset");

    // A single line bit x0 yields descrambled bits 0, 39 (x0 via tap 39)
    // and 58 (x0 via tap 58); the next all-zero block sees no history bit.
    blk(2'b01, 64'h1, 1'b1, 64'h0400_0080_0000_0001, 1'b0, 1'b0);
    blk(2'b01, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0);

    // Line bit 6 hits bit 45 in its own block and bit 0 of the next block.
    reset_dut();
    blk(2'b01, 64'h40, 1'b1, 64'h0000_2000_0000_0040, 1'b0, 1'b0);
    blk(2'b01, 64'h0,  1'b1, 64'h1, 1'b0, 1'b0);
    blk(2'b01, 64'h0,  1'b1, 64'h0, 1'b0, 1'b0);

    // Hunt: 63 good, one bad -> slip, hold 2, then 64 good -> lock.
    reset_dut();
    for (int i = 0; i < 63; i++) blk(2'b01, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0);
    blk(2'b11, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) blk(2'b10, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) blk(2'b01, 64'd0, 1'b1, 64'd0, (i == 63), 1'b0);

    // Window 1: 15 bad headers, lock held, counters cleared at window end.
    for (int i = 0; i < 64; i++) begin
      h = ((i % 4 == 0) && (i < 60)) ? 2'b11 : 2'b01;
      blk(h, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    end
    // Window 2: 16th bad header at block 60 drops lock and slips.
    for (int i = 0; i < 64; i++) begin
      h = (i % 4 == 0) ? 2'b00 : 2'b10;
      blk(h, 64'd0, 1'b1, 64'd0, (i < 60), (i == 60));
    end

    // Loopback through the golden scrambler with random gaps.
    reset_dut();
    scr_state = 58'h2A5_5A5A_1234_5678;
    n_valid   = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(99) < 70) begin
        pay = {$urandom, $urandom};
        scramble(pay, scr);
        n_valid++;
        h = ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
        blk(h, scr, (n_valid > 1), pay, (n_valid >= 64), 1'b0);
      end else begin
        exp_t e;
        e = '{default: '0};
        drive(1'b0, 2'($urandom_range(3)), {$urandom, $urandom}, e);
      end
    end

    // Reset while locked with live history: the presented block is dropped.
    reset         = 1'b1;
    bus.rx_valid  = 1'b1;
    bus.rx_header = 2'b01;
    bus.rx_data   = 64'hDEAD_BEEF_0123_4567;
    @(posedge CLK);
    #1;
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    chk_all_zero("midreset");
    blk(2'b01, 64'h1, 1'b1, 64'h0400_0080_0000_0001, 1'b0, 1'b0);

    repeat (3) idle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
